seq_multiplier: RTL



---
 rtl/seq_multiplier_if.sv | 22 ++
 rtl/seq_multiplier.sv | 114 +++++++++++
 2 files changed

// File: rtl/seq_multiplier_if.sv
// Start/busy/done handshake and operand/product bus for seq_multiplier.
// The master issues requests; the slave (the multiplier) returns status and product.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] prod;

  modport master (
    output start, a, b,
    input  busy, done, prod
  );

  modport slave (
    input  start, a, b,
    output busy, done, prod
  );
endinterface

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: WIDTH x WIDTH product over WIDTH cycles.
// Signed mode multiplies magnitudes and applies the sign to the final product.
module seq_multiplier #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SIGNED = 0
) (
  input logic             clk,
  input logic             rst_n,
  seq_multiplier_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] addend, acc_sum;

  // Magnitude of the most negative value still fits in WIDTH unsigned bits.
  always_comb begin
    a_neg = (SIGNED != 0) && bus.a[WIDTH-1];
    b_neg = (SIGNED != 0) && bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
  end

  always_comb begin
    addend  = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
    acc_sum = acc_q + addend;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    prod_d   = prod_q;

    case (state_q)
      RUN: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          prod_d  = neg_q ? -acc_sum : acc_sum;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: begin
        // IDLE and DONE accept a new request identically.
        if (bus.start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = a_neg ^ b_neg;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      prod_q   <= prod_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.prod = prod_q;

endmodule
